// File: rtl/cd_multi_pkg.sv
// Shared constants and configuration checks for the multi-channel clock divider.
// Pure definitions: no latency, no flow control.
package cd_multi_pkg;

  localparam int CTRL_EN_BIT = 0;

  // Config address MSB selects ctrl (1) versus limit (0) writes.
  function automatic int addr_ctrl_bit(input int addr_w);
    return addr_w - 1;
  endfunction

  function automatic bit cfg_ok(input int num_ch, input int cnt_w,
                                input int addr_w, input int data_w);
    return (data_w >= cnt_w) && (num_ch >= 1) && (num_ch <= 8) &&
           (num_ch <= (1 << (addr_w - 1)));
  endfunction

endpackage

// File: rtl/cd_channel.sv
// One divider channel: counter, active/shadow limit, enable, divided clock, wrap tick (CD_TICK_EN).
// New limits take effect at the next wrap; pending blocks further limit writes until then.
module cd_channel
  import cd_multi_pkg::*;
#(
  parameter int                   WIDTH_CNT = 16,
  parameter logic [WIDTH_CNT-1:0] RST_LIMIT = 1,
  parameter logic                 RST_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_limit,
  input  logic                 wr_ctrl,
  input  logic [WIDTH_CNT-1:0] wr_data,
  input  logic                 wr_en,
  output logic                 pending,
  output logic                 clk_out,
  output logic                 tick
);

  logic [WIDTH_CNT-1:0] cnt;
  logic [WIDTH_CNT-1:0] limit;
  logic [WIDTH_CNT-1:0] shadow;
  logic                 en;
  logic                 wrap;
  logic                 disable_now;
  logic                 enable_now;

  assign wrap        = en && (cnt == limit);
  assign disable_now = wr_ctrl & ~wr_en;
  assign enable_now  = wr_ctrl & wr_en & ~en;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      pending <= 1'b0;
      limit   <= RST_LIMIT;
      shadow  <= RST_LIMIT;
      en      <= RST_EN;
    end else if (disable_now) begin
      en      <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      pending <= 1'b0;
      if (pending) limit <= shadow;
    end else if (enable_now) begin
      en      <= 1'b1;
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        // A write landing on the wrap cycle bypasses the shadow entirely.
        cnt     <= '0;
        clk_out <= ~clk_out;
        pending <= 1'b0;
        if (wr_limit)     limit <= wr_data;
        else if (pending) limit <= shadow;
      end else begin
        cnt <= cnt + WIDTH_CNT'(1);
        if (wr_limit) begin
          shadow  <= wr_data;
          pending <= 1'b1;
        end
      end
    end else if (wr_limit) begin
      limit <= wr_data;
    end
  end

`ifdef CD_TICK_EN
  always_ff @(posedge clk) begin
    if (rst) tick <= 1'b0;
    else     tick <= wrap & ~disable_now;
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/cd_multi_divider.sv
// N-channel programmable clock divider; config writes stall (c_ready low) while the target channel
// has a limit pending. Optional wrap ticks under CD_TICK_EN; c_err is sticky until rst.
module cd_multi_divider
  import cd_multi_pkg::*;
#(
  parameter int                          NUM_CH            = 4,
  parameter int                          WIDTH_CNT         = 16,
  parameter int                          WIDTH_CONFIG_ADDR = 4,
  parameter int                          WIDTH_CONFIG_DATA = 16,
  parameter logic [NUM_CH*WIDTH_CNT-1:0] RST_LIMIT = {NUM_CH{{{(WIDTH_CNT-1){1'b0}}, 1'b1}}},
  parameter logic [NUM_CH-1:0]           RST_EN    = {NUM_CH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
  input  logic                         c_valid,
  output logic                         c_ready,
  output logic [NUM_CH-1:0]            clk_out,
  output logic [NUM_CH-1:0]            ch_tick,
  output logic                         c_err
);

  localparam int ADDR_CTRL_BIT = addr_ctrl_bit(WIDTH_CONFIG_ADDR);
  localparam int CH_W          = WIDTH_CONFIG_ADDR - 1;

  if (!cfg_ok(NUM_CH, WIDTH_CNT, WIDTH_CONFIG_ADDR, WIDTH_CONFIG_DATA)) begin : g_cfg_err
    $error("cd_multi_divider: unsupported NUM_CH/width combination");
  end

  logic [CH_W-1:0]   ch;
  logic              is_ctrl;
  logic              ch_ok;
  logic              ch_pend;
  logic              accept;
  logic [NUM_CH-1:0] pending;

  assign ch      = c_addr[CH_W-1:0];
  assign is_ctrl = c_addr[ADDR_CTRL_BIT];

  always_comb begin
    ch_ok   = 1'b0;
    ch_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) begin
        ch_ok   = 1'b1;
        ch_pend = pending[i];
      end
    end
  end

  // Writes to nonexistent channels are always accepted so the master never stalls on them.
  assign c_ready = ch_ok ? ~ch_pend : 1'b1;
  assign accept  = c_valid & c_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cd_channel #(
      .WIDTH_CNT (WIDTH_CNT),
      .RST_LIMIT (RST_LIMIT[g*WIDTH_CNT +: WIDTH_CNT]),
      .RST_EN    (RST_EN[g])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_limit (accept & ~is_ctrl & (ch == CH_W'(g))),
      .wr_ctrl  (accept &  is_ctrl & (ch == CH_W'(g))),
      .wr_data  (c_data[WIDTH_CNT-1:0]),
      .wr_en    (c_data[CTRL_EN_BIT]),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .tick     (ch_tick[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)                  c_err <= 1'b0;
    else if (accept & ~ch_ok) c_err <= 1'b1;
  end

endmodule

// File: tb/tb_cd_multi_divider.sv
// Randomized scoreboard bench for cd_multi_divider against a countdown-based reference model.
module tb_cd_multi_divider;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     c_addr = '0;
  logic [15:0]    c_data = '0;
  logic           c_valid = 1'b0;
  logic           c_ready;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] ch_tick;
  logic           c_err;

  cd_multi_divider dut (
    .clk     (clk),
    .rst     (rst),
    .c_addr  (c_addr),
    .c_data  (c_data),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .clk_out (clk_out),
    .ch_tick (ch_tick),
    .c_err   (c_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] clko;
    logic [3:0] tick;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: each enabled channel counts down the cycles left until its next toggle.
  int lim[NCH], shadow[NCH], rem[NCH];
  bit pend[NCH], en[NCH], lvl[NCH], tk[NCH];
  bit merr;
  bit mvalid = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit acc, input logic [3:0] a, input logic [15:0] d);
    int chn;
    bit ctrl, wl, wc;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        lim[i] = 1; shadow[i] = 1; pend[i] = 0; en[i] = 1;
        lvl[i] = 0; tk[i] = 0; rem[i] = 2;
      end
      merr = 0;
      return;
    end
    ctrl = a[3];
    chn  = int'(a[2:0]);
    for (int i = 0; i < NCH; i++) begin
      wl = acc && !ctrl && (chn == i);
      wc = acc &&  ctrl && (chn == i);
      tk[i] = 0;
      if (wc && !d[0]) begin
        en[i] = 0; lvl[i] = 0;
        if (pend[i]) lim[i] = shadow[i];
        pend[i] = 0;
      end else if (wc && d[0] && !en[i]) begin
        en[i] = 1; lvl[i] = 0; rem[i] = lim[i] + 1;
      end else if (en[i]) begin
        if (rem[i] == 1) begin
          lvl[i] = !lvl[i];
          tk[i]  = 1;
          if (wl)           lim[i] = int'(d);
          else if (pend[i]) lim[i] = shadow[i];
          pend[i] = 0;
          rem[i]  = lim[i] + 1;
        end else begin
          rem[i]--;
          if (wl) begin shadow[i] = int'(d); pend[i] = 1; end
        end
      end else if (wl) begin
        lim[i] = int'(d);
      end
    end
    if (acc && chn >= NCH) merr = 1;
  endtask

  // One clock cycle: drive new inputs, queue the expected outputs, advance the model.
  task automatic cycle(input bit r, input bit v, input logic [3:0] a, input logic [15:0] d);
    exp_t e;
    int   chn;
    bit   rdy;
    @(posedge clk);
    #1;
    rst = r; c_valid = v; c_addr = a; c_data = d;
    chn = int'(a[2:0]);
    rdy = (chn < NCH) ? !pend[chn] : 1'b1;
    if (mvalid) begin
      for (int i = 0; i < NCH; i++) begin
        e.clko[i] = lvl[i];
`ifdef CD_TICK_EN
        e.tick[i] = tk[i];
`else
        e.tick[i] = 1'b0;
`endif
      end
      e.err = merr;
      e.rdy = rdy;
      sbq.push_back(e);
    end
    model_step(r, v && rdy, a, d);
    if (r) mvalid = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("clk_out", clk_out, e.clko);
      chk("ch_tick", ch_tick, e.tick);
      chk("c_err",   {3'b0, c_err},   {3'b0, e.err});
      chk("c_ready", {3'b0, c_ready}, {3'b0, e.rdy});
    end
  end

  initial begin
    logic [3:0]  a;
    logic [15:0] d;
    bit          r, v, ctrl;
    cycle(1, 0, 4'h0, 16'h0);
    cycle(1, 0, 4'h0, 16'h0);
    repeat (16) cycle(0, 0, 4'h0, 16'h0);
    cycle(0, 1, 4'h1, 16'd4);
    repeat (24) cycle(0, 0, 4'h0, 16'h0);
    cycle(0, 1, 4'hB, 16'h0);
    repeat (6) cycle(0, 0, 4'h0, 16'h0);
    cycle(0, 1, 4'hB, 16'h1);
    repeat (10) cycle(0, 0, 4'h0, 16'h0);
    cycle(0, 1, 4'h7, 16'd5);
    repeat (4) cycle(0, 0, 4'h0, 16'h0);
    cycle(0, 1, 4'h2, 16'd2);
    repeat (3) cycle(0, 0, 4'h0, 16'h0);
    cycle(0, 1, 4'h0, 16'd3);
    cycle(1, 0, 4'h0, 16'h0);
    repeat (8) cycle(0, 0, 4'h0, 16'h0);

    for (int n = 0; n < 4000; n++) begin
      r    = ($urandom_range(0, 499) == 0);
      v    = ($urandom_range(0, 2) == 0);
      ctrl = ($urandom_range(0, 3) == 0);
      a[2:0] = ($urandom_range(0, 7) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a[3]   = ctrl;
      if (ctrl)
        d = {15'($urandom_range(0, 32767)), 1'($urandom_range(0, 3) != 0)};
      else
        d = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 6));
      cycle(r, v, a, d);
    end
    repeat (3) cycle(0, 0, 4'h0, 16'h0);
    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 4'(sbq.size()), 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
